// File: rtl/bcd_convert_seq_if.sv
// Request (start, bin_in) and registered result bundle of the serial binary-to-BCD converter.
interface bcd_convert_seq_if #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 10
);
  logic                 start;
  logic [BIN_WIDTH-1:0] bin_in;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [4*DIGITS-1:0]  bcd_out;
  logic [DIGITS-1:0]    blank;

  modport master (output start, bin_in, input busy, done, overflow, bcd_out, blank);
  modport slave  (input start, bin_in, output busy, done, overflow, bcd_out, blank);
endinterface

// File: rtl/bcd_convert_seq.sv
// Shift-add-3 binary-to-BCD converter, one bit per clock; done pulses BIN_WIDTH+1 edges after accept.
// No backpressure: start is only sampled in IDLE, requests while busy are dropped, results held until next done.
module bcd_convert_seq #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 10
) (
  input logic               Clock,
  input logic               Reset,
  bcd_convert_seq_if.slave  bus
);

  localparam int                CW        = $clog2(BIN_WIDTH + 1);
  localparam int                BCD_W     = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] bin_sr, bin_sr_nxt;
  logic [BCD_W-1:0]     scratch, scratch_nxt;
  logic                 ovf_flag, ovf_flag_nxt;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;

  logic                 done_r, done_nxt;
  logic                 overflow_r, overflow_nxt;
  logic [BCD_W-1:0]     bcd_r, bcd_nxt;
  logic [DIGITS-1:0]    blank_r, blank_nxt;

  logic [BCD_W-1:0]     adj;
  logic [BCD_W-1:0]     result;
  logic [DIGITS-1:0]    res_blank;
  logic                 zero_above;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      bin_sr     <= '0;
      scratch    <= '0;
      ovf_flag   <= 1'b0;
      bit_cnt    <= '0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      bcd_r      <= '0;
      blank_r    <= BLANK_RST;
    end else begin
      state      <= state_nxt;
      bin_sr     <= bin_sr_nxt;
      scratch    <= scratch_nxt;
      ovf_flag   <= ovf_flag_nxt;
      bit_cnt    <= bit_cnt_nxt;
      done_r     <= done_nxt;
      overflow_r <= overflow_nxt;
      bcd_r      <= bcd_nxt;
      blank_r    <= blank_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bin_sr_nxt   = bin_sr;
    scratch_nxt  = scratch;
    ovf_flag_nxt = ovf_flag;
    bit_cnt_nxt  = bit_cnt;
    done_nxt     = 1'b0;
    overflow_nxt = overflow_r;
    bcd_nxt      = bcd_r;
    blank_nxt    = blank_r;

    // Per-digit +3 correction; digits are independent, no carry between them.
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end

    result     = ovf_flag ? {DIGITS{4'h9}} : scratch;
    res_blank  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (result[4*i +: 4] == 4'd0);
      res_blank[i] = zero_above;
    end

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt    = SHIFT;
          bin_sr_nxt   = bus.bin_in;
          scratch_nxt  = '0;
          ovf_flag_nxt = 1'b0;
          bit_cnt_nxt  = CW'(BIN_WIDTH);
        end
      end
      SHIFT: begin
        // The bit pushed out of the top digit means the value no longer fits in DIGITS digits.
        {scratch_nxt, bin_sr_nxt} = {adj[BCD_W-2:0], bin_sr, 1'b0};
        ovf_flag_nxt = ovf_flag | adj[BCD_W-1];
        bit_cnt_nxt  = bit_cnt - CW'(1);
        if (bit_cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done_nxt     = 1'b1;
        overflow_nxt = ovf_flag;
        bcd_nxt      = result;
        blank_nxt    = res_blank;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.overflow = overflow_r;
  assign bus.bcd_out  = bcd_r;
  assign bus.blank    = blank_r;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Randomized bench for bcd_convert_seq in two configurations (32,10) and (10,3) against an arithmetic model.
module tb_bcd_convert_seq;

  typedef struct packed {
    logic [63:0] bcd;
    logic [15:0] blank;
    logic        ovf;
  } res_t;

  typedef struct {
    int   cyc;
    res_t r;
  } pend_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  bcd_convert_seq_if #(.BIN_WIDTH(32), .DIGITS(10)) bus_a ();
  bcd_convert_seq_if #(.BIN_WIDTH(10), .DIGITS(3))  bus_b ();

  bcd_convert_seq #(.BIN_WIDTH(32), .DIGITS(10)) dut_a (.Clock(Clock), .Reset(Reset), .bus(bus_a));
  bcd_convert_seq #(.BIN_WIDTH(10), .DIGITS(3))  dut_b (.Clock(Clock), .Reset(Reset), .bus(bus_b));

  int ecnt = 0;
  always @(posedge Clock) ecnt <= ecnt + 1;

  int          bw[2]   = '{32, 10};
  int          dg[2]   = '{10, 3};
  logic [63:0] mask[2] = '{64'hFFFF_FFFF, 64'h3FF};
  int          next_ok[2], blo[2], bhi[2], last_acc[2];
  res_t        held[2];
  pend_t       q_a[$], q_b[$];
  int          n_vec = 0, n_bad = 0;
  bit          chk_en = 1'b0;

  function automatic logic [63:0] p10(input int k);
    logic [63:0] p = 64'd1;
    for (int i = 0; i < k; i++) p = p * 64'd10;
    return p;
  endfunction

  // Decimal result of v in d digits: saturate to all nines when v does not fit.
  function automatic res_t model(input logic [63:0] v, input int d);
    res_t e;
    logic [63:0] t;
    e = '0;
    if (v >= p10(d)) begin
      e.ovf = 1'b1;
      for (int i = 0; i < d; i++) e.bcd[4*i +: 4] = 4'd9;
    end else begin
      t = v;
      for (int i = 0; i < d; i++) begin
        e.bcd[4*i +: 4] = 4'(t % 64'd10);
        t = t / 64'd10;
      end
      for (int i = 1; i < d; i++) e.blank[i] = (v < p10(i));
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input int id, input logic s, input logic [63:0] v);
    if (id == 0) begin
      bus_a.start  = s;
      bus_a.bin_in = v[31:0];
    end else begin
      bus_b.start  = s;
      bus_b.bin_in = v[9:0];
    end
  endtask

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    for (int id = 0; id < 2; id++) begin
      held[id] = model(64'd0, dg[id]);
      blo[id]  = 1;
      bhi[id]  = 0;
    end
  endtask

  // Present v so it is accepted at the earliest legal edge; with hold, keep start high while busy.
  task automatic run(input int id, input logic [63:0] v, input bit hold);
    pend_t pe;
    int    acc;
    while (ecnt + 1 < next_ok[id]) tick();
    drive(id, 1'b1, v);
    acc          = ecnt + 1;
    pe.cyc       = acc + bw[id] + 1;
    pe.r         = model(v & mask[id], dg[id]);
    if (id == 0) q_a.push_back(pe);
    else         q_b.push_back(pe);
    blo[id]      = acc;
    bhi[id]      = acc + bw[id];
    next_ok[id]  = acc + bw[id] + 2;
    last_acc[id] = acc;
    tick();
    if (hold) begin
      for (int k = 0; k <= bw[id]; k++) begin
        drive(id, 1'b1, {$urandom, $urandom});
        tick();
      end
    end else begin
      drive(id, 1'b0, {$urandom, $urandom});
    end
  endtask

  task automatic settle(input int id, output int done_edge);
    bit seen = 1'b0;
    done_edge = -1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge Clock);
      if ((id == 0) ? bus_a.done : bus_b.done) begin
        seen      = 1'b1;
        done_edge = ecnt;
      end
    end
    if (!seen) chk((id == 0) ? "a_done_timeout" : "b_done_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic cmp(input int id);
    bit    ed = 1'b0;
    res_t  got = '0;
    logic  gd, gb;
    string p = (id == 0) ? "a" : "b";
    if (id == 0) begin
      if (q_a.size() > 0 && q_a[0].cyc == ecnt) begin
        ed = 1'b1;
        held[0] = q_a[0].r;
        void'(q_a.pop_front());
      end
      got.bcd = 64'(bus_a.bcd_out); got.blank = 16'(bus_a.blank); got.ovf = bus_a.overflow;
      gd = bus_a.done; gb = bus_a.busy;
    end else begin
      if (q_b.size() > 0 && q_b[0].cyc == ecnt) begin
        ed = 1'b1;
        held[1] = q_b[0].r;
        void'(q_b.pop_front());
      end
      got.bcd = 64'(bus_b.bcd_out); got.blank = 16'(bus_b.blank); got.ovf = bus_b.overflow;
      gd = bus_b.done; gb = bus_b.busy;
    end
    chk({p, "_done"},     64'(gd), 64'(ed));
    chk({p, "_busy"},     64'(gb), 64'(ecnt >= blo[id] && ecnt <= bhi[id]));
    chk({p, "_bcd"},      got.bcd, held[id].bcd);
    chk({p, "_blank"},    64'(got.blank), 64'(held[id].blank));
    chk({p, "_overflow"}, 64'(got.ovf), 64'(held[id].ovf));
  endtask

  always @(negedge Clock) begin
    if (chk_en && !Reset) begin
      cmp(0);
      cmp(1);
    end
  end

  task automatic rnd(input int id, input int n);
    bit          prev_hold = 1'b0;
    bit          h;
    logic [63:0] v;
    int          e;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0:       v = p10($urandom_range(1, (id == 0) ? 9 : 3)) - 64'($urandom_range(0, 1));
        1:       v = 64'($urandom_range(0, 20));
        2:       v = mask[id];
        default: v = {$urandom, $urandom} & mask[id];
      endcase
      if (!prev_hold && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      h = (i < n - 1) && ($urandom_range(0, 9) == 0);
      run(id, v, h);
      prev_hold = h;
    end
    settle(id, e);
  endtask

  initial begin
    res_t m;
    int   e1, a1;
    drive(0, 1'b0, 64'd0);
    drive(1, 1'b0, 64'd0);
    model_reset();

    #12;
    chk("rst_a_busy",  64'(bus_a.busy),     64'd0);
    chk("rst_a_done",  64'(bus_a.done),     64'd0);
    chk("rst_a_bcd",   64'(bus_a.bcd_out),  64'd0);
    chk("rst_a_ovf",   64'(bus_a.overflow), 64'd0);
    chk("rst_a_blank", 64'(bus_a.blank),    64'h3FE);
    chk("rst_b_blank", 64'(bus_b.blank),    64'h6);
    #10 Reset = 1'b0;
    tick();
    next_ok[0] = ecnt + 1;
    next_ok[1] = ecnt + 1;
    chk_en     = 1'b1;

    m = model(64'd0, 10);             chk("model_zero_blank", 64'(m.blank), 64'h3FE);
    m = model(64'hFFFF_FFFF, 10);     chk("model_max32_bcd",  m.bcd, 64'h42_9496_7295);
    m = model(64'd1023, 3);           chk("model_1023_bcd",   m.bcd, 64'h999);
                                      chk("model_1023_ovf",   64'(m.ovf), 64'd1);
    m = model(64'd7, 3);              chk("model_7_blank",    64'(m.blank), 64'h6);
    m = model(64'd12345678, 10);      chk("model_1234_blank", 64'(m.blank), 64'h300);

    run(0, 64'd0, 1'b0);
    settle(0, e1);
    chk("t1_latency", 64'(e1 - last_acc[0]), 64'd33);
    chk("t1_bcd",     64'(bus_a.bcd_out), 64'd0);
    chk("t1_blank",   64'(bus_a.blank),   64'h3FE);
    chk("t1_ovf",     64'(bus_a.overflow), 64'd0);

    run(0, 64'hFFFF_FFFF, 1'b0);
    settle(0, e1);
    chk("t2_bcd",   64'(bus_a.bcd_out), 64'h42_9496_7295);
    chk("t2_blank", 64'(bus_a.blank),   64'h0);
    chk("t2_ovf",   64'(bus_a.overflow), 64'd0);

    run(0, 64'd12345678, 1'b1);
    a1 = last_acc[0];
    run(0, 64'd100, 1'b0);
    chk("t4_bcd",   64'(bus_a.bcd_out), 64'h00_1234_5678);
    chk("t4_blank", 64'(bus_a.blank),   64'h300);
    settle(0, e1);
    chk("t4_second_done", 64'(e1 - a1), 64'd67);
    chk("t4_bcd2",   64'(bus_a.bcd_out), 64'h100);
    chk("t4_blank2", 64'(bus_a.blank),   64'h3F8);

    run(1, 64'd999, 1'b0);
    settle(1, e1);
    chk("t3_latency", 64'(e1 - last_acc[1]), 64'd11);
    chk("t3_999_bcd", 64'(bus_b.bcd_out), 64'h999);
    chk("t3_999_ovf", 64'(bus_b.overflow), 64'd0);
    run(1, 64'd1023, 1'b0);
    settle(1, e1);
    chk("t3_1023_bcd",   64'(bus_b.bcd_out), 64'h999);
    chk("t3_1023_ovf",   64'(bus_b.overflow), 64'd1);
    chk("t3_1023_blank", 64'(bus_b.blank),   64'h0);
    run(1, 64'd7, 1'b0);
    settle(1, e1);
    chk("t3_7_bcd",   64'(bus_b.bcd_out), 64'h007);
    chk("t3_7_blank", 64'(bus_b.blank),   64'h6);

    run(0, 64'd4000000000, 1'b0);
    run(1, 64'd512, 1'b0);
    repeat (4) tick();
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("t5_a_busy",  64'(bus_a.busy),     64'd0);
    chk("t5_a_done",  64'(bus_a.done),     64'd0);
    chk("t5_a_bcd",   64'(bus_a.bcd_out),  64'd0);
    chk("t5_a_ovf",   64'(bus_a.overflow), 64'd0);
    chk("t5_a_blank", 64'(bus_a.blank),    64'h3FE);
    chk("t5_b_busy",  64'(bus_b.busy),     64'd0);
    chk("t5_b_bcd",   64'(bus_b.bcd_out),  64'd0);
    chk("t5_b_blank", 64'(bus_b.blank),    64'h6);
    tick();
    #2 Reset = 1'b0;
    tick();
    next_ok[0] = ecnt + 1;
    next_ok[1] = ecnt + 1;
    run(0, 64'd987654321, 1'b0);
    settle(0, e1);
    chk("t5_fresh_bcd", 64'(bus_a.bcd_out), 64'h09_8765_4321);
    run(1, 64'd1000, 1'b0);
    settle(1, e1);
    chk("t5_fresh_ovf", 64'(bus_b.overflow), 64'd1);

    fork
      rnd(0, 1000);
      rnd(1, 2000);
    join

    repeat (2) tick();
    chk("queues_drained", 64'(q_a.size() + q_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
